// File: rtl/trng_pkg.sv
// ----------------------------------------------------------------------------
// trng_pkg: shared types and LFSR tap masks for the TRNG conditioner. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package trng_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'd0,
    MODE_VN       = 2'd1,
    MODE_VN_WHITE = 2'd2,
    MODE_WHITE    = 2'd3
  } mode_e;

  typedef enum logic {
    VN_EMPTY      = 1'b0,
    VN_HAVE_FIRST = 1'b1
  } vn_state_e;

  // Bit (n-1) set for tap n of a maximal-length Fibonacci polynomial.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       lfsr_taps = 32'h0000_00B8;
      24:      lfsr_taps = 32'h00E1_0000;
      32:      lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = 32'h0000_D008;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/trng_if.sv
// ----------------------------------------------------------------------------
// trng_if: raw-bit input and conditioned-word output streams. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface trng_if #(
  parameter int WORD_W = 8
);
  logic              raw_bit;
  logic              raw_valid;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (output raw_bit, raw_valid, word_ready, input word_out, word_valid);
  modport slave  (input raw_bit, raw_valid, word_ready, output word_out, word_valid);
endinterface

`default_nettype wire

// File: rtl/trng_fifo.sv
// ----------------------------------------------------------------------------
// trng_fifo: power-of-two synchronous FIFO, registered output only. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module trng_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push_i,
  input  wire logic [WIDTH-1:0]         data_i,
  input  wire logic                     pop_i,
  output logic      [WIDTH-1:0]         data_o,
  output logic      [$clog2(DEPTH):0]   level_o,
  output logic                          full_o,
  output logic                          empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    level_q;
  logic             wr_en, rd_en;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/trng_conditioner.sv
// ----------------------------------------------------------------------------
// trng_conditioner: health-tested VN/LFSR conditioning into a word FIFO. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module trng_conditioner
  import trng_pkg::*;
#(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LFSR_W     = 16,
  parameter int RCT_LIMIT  = 8
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  trng_if.slave                            bus,
  input  wire mode_e                       mode_i,
  input  wire logic                        clear_fail_i,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level_o,
  output logic                             health_fail_o,
  output logic                             overflow_o
);
  localparam int CNT_W = $clog2(WORD_W);
  localparam int RUN_W = $clog2(RCT_LIMIT + 1);
  localparam logic [31:0]       C_TAPS_FULL = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] C_TAPS      = C_TAPS_FULL[LFSR_W-1:0];

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  mode_e             mode_q;
  vn_state_e         vn_q, vn_d;
  logic              first_q, first_d;
  logic [WORD_W-1:0] acc_q, acc_d, word_full;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              last_q, last_d;
  logic              fail_q, fail_d, ovf_q, ovf_d;
  logic              mode_chg, use_vn, whiten, cbit, cvalid, cbit_w;
  logic              push, pop, fail_set, drop, fifo_full, fifo_empty;

  assign lfsr_d   = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & C_TAPS)};
  assign mode_chg = (mode_i != mode_q);
  assign use_vn   = (mode_i == MODE_VN) || (mode_i == MODE_VN_WHITE);
  assign whiten   = (mode_i == MODE_WHITE) || (mode_i == MODE_VN_WHITE);
  assign pop      = bus.word_valid && bus.word_ready;

  always_comb begin
    vn_d    = vn_q;
    first_d = first_q;
    cbit    = bus.raw_bit;
    cvalid  = 1'b0;
    if (bus.raw_valid) begin
      if (!use_vn) begin
        cvalid = 1'b1;
      end else begin
        case (vn_q)
          VN_EMPTY: begin
            vn_d    = VN_HAVE_FIRST;
            first_d = bus.raw_bit;
          end
          VN_HAVE_FIRST: begin
            vn_d   = VN_EMPTY;
            cvalid = (bus.raw_bit != first_q);
            cbit   = first_q;
          end
          default: vn_d = VN_EMPTY;
        endcase
      end
    end
    if (fail_q || mode_chg) begin
      vn_d   = VN_EMPTY;
      cvalid = 1'b0;
    end
    cbit_w = cbit ^ (whiten & lfsr_q[0]);
  end

  always_comb begin
    acc_d             = acc_q;
    bcnt_d            = bcnt_q;
    push              = 1'b0;
    word_full         = acc_q;
    word_full[bcnt_q] = cbit_w;
    if (fail_q || mode_chg) begin
      acc_d  = '0;
      bcnt_d = '0;
    end else if (cvalid) begin
      if (bcnt_q == CNT_W'(WORD_W - 1)) begin
        push   = 1'b1;
        acc_d  = '0;
        bcnt_d = '0;
      end else begin
        acc_d  = word_full;
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // Run length is taken on raw bits, independent of the conditioning mode.
  always_comb begin
    run_d    = run_q;
    last_d   = last_q;
    fail_set = 1'b0;
    if (bus.raw_valid) begin
      last_d = bus.raw_bit;
      if ((bus.raw_bit != last_q) || (run_q == '0)) run_d = RUN_W'(1);
      else if (run_q != RUN_W'(RCT_LIMIT))         run_d = run_q + 1'b1;
      fail_set = (run_d == RUN_W'(RCT_LIMIT));
    end
    if (clear_fail_i) run_d = '0;
    drop   = push && fifo_full && !pop;
    fail_d = fail_set ? 1'b1 : (clear_fail_i ? 1'b0 : fail_q);
    ovf_d  = drop     ? 1'b1 : (clear_fail_i ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= LFSR_W'(1);
      mode_q  <= MODE_BYPASS;
      vn_q    <= VN_EMPTY;
      first_q <= 1'b0;
      acc_q   <= '0;
      bcnt_q  <= '0;
      run_q   <= '0;
      last_q  <= 1'b0;
      fail_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      mode_q  <= mode_i;
      vn_q    <= vn_d;
      first_q <= first_d;
      acc_q   <= acc_d;
      bcnt_q  <= bcnt_d;
      run_q   <= run_d;
      last_q  <= last_d;
      fail_q  <= fail_d;
      ovf_q   <= ovf_d;
    end
  end

  trng_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (word_full),
    .pop_i   (pop),
    .data_o  (bus.word_out),
    .level_o (fifo_level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.word_valid = !fifo_empty;
  assign health_fail_o  = fail_q;
  assign overflow_o     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_trng_conditioner.sv
// ----------------------------------------------------------------------------
// tb_trng_conditioner: directed scoreboard bench for trng_conditioner. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_trng_conditioner;
  import trng_pkg::*;

  logic       clk;
  logic       rst_n;
  mode_e      mode;
  logic       clear_fail;
  logic [2:0] fifo_level;
  logic       health_fail;
  logic       overflow;

  trng_if #(.WORD_W(8)) bus ();

  trng_conditioner #(
    .WORD_W     (8),
    .FIFO_DEPTH (4),
    .LFSR_W     (16),
    .RCT_LIMIT  (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .mode_i        (mode),
    .clear_fail_i  (clear_fail),
    .fifo_level_o  (fifo_level),
    .health_fail_o (health_fail),
    .overflow_o    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  m_acc;
  int          m_bcnt;
  logic [15:0] m_lfsr;
  logic [7:0]  hold_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score any handshake, advance the LFSR model, return at negedge.
  task automatic tick();
    if (bus.word_valid && bus.word_ready) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else                   check("pop_word", bus.word_out, exp_q.pop_front());
    end
    @(posedge clk);
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
    @(negedge clk);
  endtask

  task automatic emit(input logic b);
    int pop_now;
    m_acc[m_bcnt] = b;
    m_bcnt++;
    if (m_bcnt == 8) begin
      pop_now = (bus.word_ready && exp_q.size() > 0) ? 1 : 0;
      if (exp_q.size() - pop_now < 4) exp_q.push_back(m_acc);
      m_acc  = '0;
      m_bcnt = 0;
    end
  endtask

  task automatic model_flush();
    m_acc  = '0;
    m_bcnt = 0;
  endtask

  task automatic send(input logic b, input logic do_emit, input logic white);
    bus.raw_valid = 1'b1;
    bus.raw_bit   = b;
    if (do_emit) emit(b ^ (white & m_lfsr[0]));
    tick();
    bus.raw_valid = 1'b0;
  endtask

  task automatic send_pair(input logic a, input logic b, input logic white);
    send(a, 1'b0, 1'b0);
    bus.raw_valid = 1'b1;
    bus.raw_bit   = b;
    if (a != b) emit(a ^ (white & m_lfsr[0]));
    tick();
    bus.raw_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic white);
    for (int i = 0; i < 8; i++) send(w[i], 1'b1, white);
  endtask

  task automatic set_mode(input mode_e m);
    mode = m;
    tick();
  endtask

  task automatic drain(input int n);
    bus.word_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    bus.word_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bypass_bits;
    logic [7:0] fill_words [5];
    logic [7:0] ovf_words  [5];
    bypass_bits   = 8'b0100_1101;
    fill_words    = '{8'hA5, 8'h3C, 8'h69, 8'hC3, 8'h5A};
    ovf_words     = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    rst_n          = 1'b1;
    mode           = MODE_BYPASS;
    clear_fail     = 1'b0;
    bus.raw_bit    = 1'b0;
    bus.raw_valid  = 1'b0;
    bus.word_ready = 1'b0;
    model_flush();
    m_lfsr = 16'h0001;
    #2 rst_n = 1'b0;
    #3;
    check("rst_word_valid", bus.word_valid, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_word_out", bus.word_out, 8'h00);
    check("rst_health", health_fail, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_lfsr = 16'h0001;
    tick();

    // BYPASS: 1,0,1,1,0,0,1,0 -> 8'h4D
    for (int i = 0; i < 7; i++) send(bypass_bits[i], 1'b1, 1'b0);
    check("byp_not_yet_valid", bus.word_valid, 1'b0);
    send(bypass_bits[7], 1'b1, 1'b0);
    check("byp_valid", bus.word_valid, 1'b1);
    check("byp_level", fifo_level, 3'd1);
    check("byp_value", bus.word_out, 8'h4D);
    drain(1);

    // VN: 10,01,11,00 repeated -> 1,0,1,0,... -> 8'h55
    set_mode(MODE_VN);
    for (int r = 0; r < 4; r++) begin
      send_pair(1'b1, 1'b0, 1'b0);
      send_pair(1'b0, 1'b1, 1'b0);
      send_pair(1'b1, 1'b1, 1'b0);
      send_pair(1'b0, 1'b0, 1'b0);
    end
    check("vn_level", fifo_level, 3'd1);
    check("vn_value", bus.word_out, 8'h55);
    drain(1);

    // WHITE and VN_WHITE against the bench LFSR
    set_mode(MODE_WHITE);
    send_word(8'h35, 1'b1);
    drain(1);
    set_mode(MODE_VN_WHITE);
    for (int r = 0; r < 4; r++) begin
      send_pair(1'b1, 1'b0, 1'b1);
      send_pair(1'b0, 1'b1, 1'b1);
      send_pair(1'b1, 1'b1, 1'b1);
      send_pair(1'b0, 1'b0, 1'b1);
    end
    check("vnw_level", fifo_level, 3'd1);
    drain(1);

    // Repetition count: 1,0,1,0 then eight 1s; failure on the 12th bit
    set_mode(MODE_BYPASS);
    send(1'b1, 1'b1, 1'b0); send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0); send(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send(1'b1, 1'b1, 1'b0);
    check("rct_not_yet", health_fail, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    check("rct_fail", health_fail, 1'b1);
    model_flush();
    for (int i = 0; i < 8; i++) send(1'(i % 2), 1'b0, 1'b0);
    check("rct_no_push", fifo_level, 3'd1);
    drain(1);
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    check("rct_cleared", health_fail, 1'b0);
    send_word(8'h96, 1'b0);
    check("rct_resume", fifo_level, 3'd1);
    drain(1);

    // Full FIFO with simultaneous push and pop
    for (int w = 0; w < 4; w++) send_word(fill_words[w], 1'b0);
    check("full_level", fifo_level, 3'd4);
    for (int i = 0; i < 7; i++) send(fill_words[4][i], 1'b1, 1'b0);
    bus.word_ready = 1'b1;
    send(fill_words[4][7], 1'b1, 1'b0);
    bus.word_ready = 1'b0;
    check("pp_level", fifo_level, 3'd4);
    check("pp_overflow", overflow, 1'b0);
    drain(4);
    check("pp_drained", fifo_level, 3'd0);

    // Overflow: five words with word_ready low
    for (int w = 0; w < 5; w++) send_word(ovf_words[w], 1'b0);
    check("ovf_level", fifo_level, 3'd4);
    check("ovf_flag", overflow, 1'b1);
    hold_exp = exp_q[0];
    tick();
    tick();
    check("ovf_hold", bus.word_out, hold_exp);
    drain(4);
    check("ovf_sticky", overflow, 1'b1);

    // Reset mid-word with a word still buffered and overflow set
    send_word(8'h0F, 1'b0);
    send(1'b1, 1'b1, 1'b0); send(1'b1, 1'b1, 1'b0); send(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.word_valid, 1'b0);
    check("mid_rst_level", fifo_level, 3'd0);
    check("mid_rst_word", bus.word_out, 8'h00);
    check("mid_rst_ovf", overflow, 1'b0);
    exp_q.delete();
    model_flush();
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_lfsr = 16'h0001;
    tick();
    check("post_rst_level", fifo_level, 3'd0);
    send_word(8'hC6, 1'b0);
    check("post_rst_level1", fifo_level, 3'd1);
    check("post_rst_word", bus.word_out, 8'hC6);
    drain(1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trng_conditioner.md
TRNG_CONDITIONER -- requirements
Module: trng_conditioner

Interface
REQ-001 Parameter WORD_W, default 8, width of each output random word (2..32).
REQ-002 Parameter FIFO_DEPTH, default 4, number of output words buffered (power of two, >=2).
REQ-003 Parameter LFSR_W, default 16, whitening LFSR width; tap set comes from the shared package.
REQ-004 Parameter RCT_LIMIT, default 8, run length of identical raw bits that declares a health failure.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 raw_bit  input  1  sampled ring-oscillator bit.
REQ-008 raw_valid  input  1  raw_bit is accepted on a clock edge when this is high.
REQ-009 mode  input  2  conditioning mode: 0 BYPASS, 1 VN (von Neumann), 2 VN_WHITE (von Neumann then LFSR XOR), 3 WHITE (LFSR XOR only).
REQ-010 clear_fail  input  1  single-cycle pulse that clears health_fail and overflow.
REQ-011 word_out  output  WORD_W  head of the FIFO.
REQ-012 word_valid  output  1  FIFO is not empty.
REQ-013 word_ready  input  1  consumer accepts the head word when word_valid and word_ready are both high.
REQ-014 fifo_level  output  clog2(FIFO_DEPTH)+1  number of words currently stored.
REQ-015 health_fail  output  1  sticky repetition-count failure flag.
REQ-016 overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-017 VN pair FSM: two states, EMPTY and HAVE_FIRST; an accepted bit in EMPTY is stored and the FSM moves to HAVE_FIRST; an accepted bit in HAVE_FIRST returns the FSM to EMPTY, emits the stored first bit if the two bits differ, and emits nothing if they are equal.
REQ-018 In BYPASS and WHITE, every accepted raw bit produces one conditioned bit in the same cycle.
REQ-019 The LFSR is Fibonacci, shifts every cycle regardless of raw_valid, and is seeded to 1 at reset; with LFSR_W=16 the taps are 16,15,13,4.
REQ-020 In WHITE and VN_WHITE, each emitted bit is XORed with LFSR bit 0 of the current cycle.
REQ-021 Conditioned bits fill an accumulator LSB-first; on the WORD_W-th bit, the completed word is pushed into the FIFO on that same edge, and word_valid is high the following cycle.
REQ-022 If the FIFO is full at push time and no pop occurs that cycle, the word is dropped and overflow is set.
REQ-023 When the FIFO is full and a push and a pop occur in the same cycle, both take effect and fifo_level is unchanged.
REQ-024 When the FIFO is empty and a push occurs, word_valid rises the next cycle; there is no fall-through path to word_out.
REQ-025 The repetition counter tracks the current run of identical accepted raw bits, measured before conditioning; when the run reaches RCT_LIMIT, health_fail is set.
REQ-026 While health_fail is high: no pushes occur, the accumulator and the VN FSM are held cleared, and FIFO contents remain poppable.
REQ-027 clear_fail clears health_fail, overflow and the run counter; if a new failure is detected in the same cycle, the set takes priority.
REQ-028 A change of mode between consecutive cycles clears the accumulator and returns the VN FSM to EMPTY; the FIFO and the LFSR are unaffected.
REQ-029 word_out holds its value while word_valid is high and word_ready is low.

Reset
REQ-030 Asserting rst_n low immediately clears the FIFO (fifo_level=0, word_valid=0, word_out=0), the accumulator, the VN FSM (EMPTY), the run counter, health_fail and overflow, and sets the LFSR to 1.
REQ-031 Reset asserted mid-word discards the partial word; no push occurs on the edge on which reset is released.

Structure
REQ-032 Package trng_pkg holds the mode enum, the VN FSM state typedef and the LFSR tap-mask function or constant indexed by LFSR_W.
REQ-033 The FIFO is a separate sub-module, trng_fifo, parameterised by width and depth, with push/pop, level and full/empty outputs.

Verification
REQ-034 mode=BYPASS, WORD_W=8, raw bits 1,0,1,1,0,0,1,0 on consecutive valid cycles -> word_out=8'h4D, word_valid high the cycle after the 8th bit.
REQ-035 mode=VN, raw pairs 10,01,11,00,10 repeated until 8 bits are emitted -> each 10 pair emits 1, each 01 emits 0, 11 and 00 emit nothing; resulting word = 8'h55 built from the emitted sequence 1,0,1,0,...
REQ-036 RCT_LIMIT=8, eight consecutive raw 1s -> health_fail high the cycle after the 8th bit; no further pushes; clear_fail -> health_fail low next cycle and collection resumes.
REQ-037 word_ready held low, 5 words produced with FIFO_DEPTH=4 -> fifo_level=4, overflow=1, the first 4 words are popped intact and in order.
REQ-038 FIFO full with push and pop in the same cycle -> fifo_level stays 4, overflow stays 0.
REQ-039 rst_n pulsed low after 3 of 8 bits -> all outputs reset; the next word contains only bits supplied after reset.
